// File: rtl/ib_sched_pkg.sv
// ib_sched_pkg: scheduler state encoding and engine busy codes.
package ib_sched_pkg;
   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_FIN, RELEASE, WAIT_IDLE, NEXT, TERM, DONE
   } state_e;
   localparam logic [1:0] BUSY_IDLE = 2'b00;
   localparam logic [1:0] BUSY_RUN  = 2'b01;
   localparam logic [1:0] BUSY_FIN  = 2'b10;
endpackage

// File: rtl/sched_wdog.sv
// sched_wdog: loadable down-counter; expires when it hits zero while enabled.
module sched_wdog #(
   parameter int CYCLES = 128
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = CYCLES > 2 ? $clog2(CYCLES) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = load_i ? CW'(CYCLES - 1) : (en_i && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
   always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   assign expired_o = en_i && cnt_q == '0;
endmodule

// File: rtl/ib_update_scheduler.sv
// ib_update_scheduler: hands the shared IB ROM port to each update engine in turn,
// counts iterations and ends a codeword on syndrome pass, iteration limit or watchdog.
module ib_update_scheduler import ib_sched_pkg::*; #(
   parameter int NUM_ENG     = 3,
   parameter int ITER_MAX    = 10,
   parameter int ITER_W      = $clog2(ITER_MAX + 1),
   parameter int WDOG_CYCLES = 128,
   parameter int SEL_W       = NUM_ENG > 1 ? $clog2(NUM_ENG) : 1
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 decode_term,
   input  logic [2*NUM_ENG-1:0] eng_busy,
   output logic [NUM_ENG-1:0]   eng_iter_rqst,
   output logic [NUM_ENG-1:0]   eng_iter_term,
   output logic [SEL_W-1:0]     rom_sel,
   output logic [ITER_W-1:0]    iter_cnt,
   output logic                 sched_busy,
   output logic                 done,
   output logic                 wdog_err
);
   state_e              state_q, state_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic [ITER_W-1:0]   iter_q, iter_d, iter_inc;
   logic                werr_q, werr_d;
   logic [1:0]          cur_busy;
   logic                wait_st, wd_exp, last;

   assign cur_busy = eng_busy[{idx_q, 1'b0} +: 2];
   assign wait_st  = state_q == WAIT_FIN || state_q == WAIT_IDLE;
   assign last     = idx_q == SEL_W'(NUM_ENG - 1);
   assign iter_inc = (iter_q == ITER_W'(ITER_MAX)) ? iter_q : iter_q + ITER_W'(1);

   // Reloading on every state change gives each wait state its own full budget.
   sched_wdog #(.CYCLES(WDOG_CYCLES)) u_wdog (
      .clk      (sys_clk),
      .rst      (rst),
      .load_i   (state_d != state_q),
      .en_i     (wait_st),
      .expired_o(wd_exp)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      iter_d  = iter_q;
      werr_d  = werr_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = ISSUE;
            idx_d   = '0;
            iter_d  = '0;
            werr_d  = 1'b0;
         end
         ISSUE:     state_d = WAIT_FIN;
         WAIT_FIN:  begin
            state_d = wd_exp ? TERM : (cur_busy == BUSY_FIN) ? RELEASE : WAIT_FIN;
            werr_d  = werr_q | wd_exp;
         end
         RELEASE:   state_d = WAIT_IDLE;
         WAIT_IDLE: begin
            state_d = wd_exp ? TERM : (cur_busy == BUSY_IDLE) ? NEXT : WAIT_IDLE;
            werr_d  = werr_q | wd_exp;
         end
         // Syndrome pass beats the iteration wrap, so the wrap is not counted.
         NEXT: if (decode_term) state_d = TERM;
         else if (last) begin
            iter_d  = iter_inc;
            state_d = (iter_inc == ITER_W'(ITER_MAX)) ? TERM : ISSUE;
            idx_d   = (iter_inc == ITER_W'(ITER_MAX)) ? idx_q : '0;
         end else begin
            idx_d   = idx_q + SEL_W'(1);
            state_d = ISSUE;
         end
         TERM:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk)
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         iter_q  <= '0;
         werr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         iter_q  <= iter_d;
         werr_q  <= werr_d;
      end

   assign eng_iter_rqst = (state_q == WAIT_FIN) ? NUM_ENG'(1) << idx_q : '0;
   assign eng_iter_term = {NUM_ENG{state_q == TERM}};
   assign rom_sel       = idx_q;
   assign iter_cnt      = iter_q;
   assign sched_busy    = state_q != IDLE;
   assign done          = state_q == DONE;
   assign wdog_err      = werr_q;
endmodule

// File: tb/tb_ib_update_scheduler.sv
// tb_ib_update_scheduler: directed runs against behavioural engine models.
module tb_ib_update_scheduler;
   import ib_sched_pkg::*;
   localparam int NE = 3, IM = 2, WD = 32;

   logic            sys_clk = 1'b0;
   logic            rst = 1'b1, start = 1'b0, decode_term = 1'b0;
   logic [2*NE-1:0] eng_busy;
   logic [NE-1:0]   eng_iter_rqst, eng_iter_term;
   logic [1:0]      rom_sel;
   logic [1:0]      iter_cnt;
   logic            sched_busy, done, wdog_err;

   int   n_chk = 0, n_err = 0;
   int   dly[NE], hold[NE];
   bit   stuck[NE];
   logic [1:0] eb[NE];
   int   ecnt[NE], hcnt[NE];
   int   rq_l[1024], sel_l[1024], it_l[1024], wd_l[1024];
   int   rise_c[$], rise_v[$];
   int   done_c, dc, tm_or, tm_n, dn_n, hi2, ign_c;
   int   exp_rq[6] = '{1, 2, 4, 1, 2, 4};

   ib_update_scheduler #(.NUM_ENG(NE), .ITER_MAX(IM), .WDOG_CYCLES(WD)) dut (
      .sys_clk      (sys_clk),
      .rst          (rst),
      .start        (start),
      .decode_term  (decode_term),
      .eng_busy     (eng_busy),
      .eng_iter_rqst(eng_iter_rqst),
      .eng_iter_term(eng_iter_term),
      .rom_sel      (rom_sel),
      .iter_cnt     (iter_cnt),
      .sched_busy   (sched_busy),
      .done         (done),
      .wdog_err     (wdog_err)
   );

   always #5 sys_clk = ~sys_clk;

   for (genvar g = 0; g < NE; g++) assign eng_busy[2*g +: 2] = eb[g];

   // Engine: finishes dly cycles after rqst, holds FIN for hold cycles after rqst drops.
   always @(posedge sys_clk)
      for (int i = 0; i < NE; i++)
         if (rst) begin
            eb[i] <= BUSY_IDLE; ecnt[i] <= 0; hcnt[i] <= 0;
         end else if (eng_iter_rqst[i]) begin
            if (stuck[i]) eb[i] <= BUSY_RUN;
            else if (eb[i] != BUSY_FIN) begin
               ecnt[i] <= ecnt[i] + 1;
               eb[i]   <= (ecnt[i] + 1 >= dly[i]) ? BUSY_FIN : BUSY_RUN;
            end
         end else if (eb[i] == BUSY_FIN) begin
            if (hcnt[i] >= hold[i]) begin
               eb[i] <= BUSY_IDLE; ecnt[i] <= 0; hcnt[i] <= 0;
            end else hcnt[i] <= hcnt[i] + 1;
         end else if (eb[i] != BUSY_IDLE) begin
            eb[i] <= BUSY_IDLE; ecnt[i] <= 0;
         end

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge sys_clk);
      #1;
   endtask

   // Cycle 0 carries the start pulse; te/ti raise decode_term during that engine's
   // WAIT_FIN in that iteration; ign re-pulses start mid-codeword.
   task automatic run_cw(input int te, input int ti, input bit ign);
      int prev = 0;
      rise_c.delete(); rise_v.delete();
      done_c = -1; tm_or = 0; tm_n = 0; dn_n = 0; hi2 = 0; ign_c = -1;
      for (int c = 0; c < 1024 && done_c < 0; c++) begin
         rq_l[c] = int'(eng_iter_rqst); sel_l[c] = int'(rom_sel);
         it_l[c] = int'(iter_cnt);      wd_l[c]  = int'(wdog_err);
         if (done) begin done_c = c; dn_n++; end
         if (eng_iter_term != 0) begin tm_or |= int'(eng_iter_term); tm_n++; end
         if (eng_iter_rqst[2]) hi2++;
         if (eng_iter_rqst != 0 && prev == 0) begin
            rise_c.push_back(c); rise_v.push_back(int'(eng_iter_rqst));
         end
         prev  = int'(eng_iter_rqst);
         start = (c == 0);
         if (ign && ign_c >= 0 && c == ign_c + 1) begin
            chk("ign_sel", int'(rom_sel), 1);
            chk("ign_iter", int'(iter_cnt), 1);
            chk("ign_busy", int'(sched_busy), 1);
         end
         if (ign && ign_c < 0 && eng_iter_rqst != 0 && rom_sel == 2'd1 && iter_cnt == 2'd1) begin
            start = 1'b1; ign_c = c;
         end
         if (te >= 0 && eng_iter_rqst != 0 && int'(rom_sel) == te && int'(iter_cnt) == ti)
            decode_term = 1'b1;
         tick;
      end
      start = 1'b0; decode_term = 1'b0;
      dc = done_c < 0 ? 0 : done_c;
      chk("done_seen", int'(done_c >= 0), 1);
      repeat (2) tick;
   endtask

   function automatic int rise_at(input int k);
      return k < rise_v.size() ? rise_v[k] : -1;
   endfunction

   initial begin
      int bad;
      for (int i = 0; i < NE; i++) begin dly[i] = 4; hold[i] = 0; stuck[i] = 0; end
      repeat (3) tick;
      chk("rst_rqst", int'(eng_iter_rqst), 0);
      chk("rst_term", int'(eng_iter_term), 0);
      chk("rst_sel", int'(rom_sel), 0);
      chk("rst_iter", int'(iter_cnt), 0);
      chk("rst_busy", int'(sched_busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_wdog", int'(wdog_err), 0);
      rst = 1'b0;
      tick;
      chk("idle_busy", int'(sched_busy), 0);

      run_cw(-1, 0, 0);
      chk("nom_done_cyc", done_c, 56);
      chk("nom_nrise", rise_v.size(), 6);
      for (int k = 0; k < 6; k++) chk($sformatf("nom_rqst%0d", k), rise_at(k), exp_rq[k]);
      chk("nom_slot", rise_c.size() > 1 ? rise_c[1] - rise_c[0] : -1, 9);
      chk("nom_iter", it_l[dc], 2);
      chk("nom_term", tm_or, 7);
      chk("nom_term_n", tm_n, 1);
      chk("nom_done_n", dn_n, 1);
      chk("nom_busy_after", int'(sched_busy), 0);

      run_cw(1, 0, 0);
      chk("dt_done_cyc", done_c, 20);
      chk("dt_nrise", rise_v.size(), 2);
      chk("dt_no_eng2", hi2, 0);
      chk("dt_term", tm_or, 7);
      chk("dt_term_n", tm_n, 1);
      chk("dt_iter", it_l[dc], 0);

      run_cw(2, 1, 0);
      chk("wrap_done_cyc", done_c, 56);
      chk("wrap_iter", it_l[dc], 1);
      chk("wrap_term_n", tm_n, 1);

      run_cw(-1, 0, 1);
      chk("ign_done_cyc", done_c, 56);
      chk("ign_iter_end", it_l[dc], 2);

      stuck[2] = 1;
      run_cw(-1, 0, 0);
      chk("wd_fin_cycles", hi2, WD);
      chk("wd_err", wd_l[dc], 1);
      chk("wd_done_cyc", done_c, 53);
      chk("wd_term", tm_or, 7);
      chk("wd_iter", it_l[dc], 0);
      stuck[2] = 0;
      repeat (2) tick;
      run_cw(-1, 0, 0);
      chk("wd_sticky", wd_l[0], 1);
      chk("wd_clear", wd_l[1], 0);
      chk("wd_rerun_done", done_c, 56);

      hold[0] = 20;
      run_cw(-1, 0, 0);
      chk("hold_gap", rise_c.size() > 1 ? rise_c[1] - rise_c[0] : -1, 29);
      bad = 0;
      for (int c = 8; c <= 29; c++) if (sel_l[c] != 0 || rq_l[c] != 0) bad++;
      chk("hold_sel_stable", bad, 0);
      chk("hold_rqst_after", rise_at(1), 2);
      chk("hold_done_cyc", done_c, 96);
      hold[0] = 0;

      hold[1] = 20;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (19) tick;
      chk("mid_sel", int'(rom_sel), 1);
      chk("mid_busy", int'(sched_busy), 1);
      rst = 1'b1;
      tick;
      chk("mrst_rqst", int'(eng_iter_rqst), 0);
      chk("mrst_term", int'(eng_iter_term), 0);
      chk("mrst_sel", int'(rom_sel), 0);
      chk("mrst_iter", int'(iter_cnt), 0);
      chk("mrst_busy", int'(sched_busy), 0);
      chk("mrst_done", int'(done), 0);
      chk("mrst_wdog", int'(wdog_err), 0);
      rst = 1'b0;
      hold[1] = 0;
      repeat (2) tick;
      chk("mrst_idle", int'(sched_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
